// File: rtl/acia_rx.sv
// acia_rx -- receive half of a 6551-style ACIA.
//
// The RX line is oversampled at OVERSAMPLE x the baud rate. The receiver
// recovers 1 start bit, 8 data bits (LSB first), an optional parity bit and
// the first stop bit. The received byte and its status flags are held for
// the host until it acknowledges them with RXREAD.
//
// Parameters:
//   OVERSAMPLE   BCLK ticks per bit (power of 2, >= 8)
//   SYNC_STAGES  flip-flops in the RX input synchroniser (2 or 3)
//
// Ports:
//   BCLK     in   16x baud clock, the only clock
//   RESET    in   active-low reset, synchronous to BCLK
//   RX       in   serial input, asynchronous, idles high
//   R_PME    in   parity enable
//   R_PMC    in   parity mode: 00 odd, 01 even, 10 mark, 11 space
//   R_SBN    in   stop-bit count select (only the first stop bit is checked)
//   RXREAD   in   one-cycle pulse: host has read RXDATA and status
//   RXDATA   out  last received byte
//   RXFULL   out  byte available
//   PERR     out  parity error on the byte in RXDATA
//   FERR     out  framing error (stop bit sampled low)
//   OVRN     out  a frame completed while RXFULL was set
//
// Build option:
//   ACIA_RX_MAJORITY_EN  each bit is the 2-of-3 majority of three adjacent
//                        samples; completion occurs one BCLK later.

module acia_rx #(
   parameter int unsigned OVERSAMPLE  = 16,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic       BCLK,
   input  logic       RESET,
   input  logic       RX,
   input  logic       R_PME,
   input  logic [1:0] R_PMC,
   input  logic       R_SBN,
   input  logic       RXREAD,
   output logic [7:0] RXDATA,
   output logic       RXFULL,
   output logic       PERR,
   output logic       FERR,
   output logic       OVRN
);

   localparam int unsigned CW = $clog2(OVERSAMPLE);

`ifdef ACIA_RX_MAJORITY_EN
   // Decisions are taken one tick after the centre sample. The start decision
   // reloads the counter with 1 so the bit grid stays where the single-sample
   // build places it; only the decision edge moves.
   localparam logic [CW-1:0] START_PT   = CW'(OVERSAMPLE / 2);
   localparam logic [CW-1:0] BIT_PT     = '0;
   localparam logic [CW-1:0] START_LOAD = CW'(1);
`else
   localparam logic [CW-1:0] START_PT   = CW'(OVERSAMPLE / 2 - 1);
   localparam logic [CW-1:0] BIT_PT     = CW'(OVERSAMPLE - 1);
   localparam logic [CW-1:0] START_LOAD = '0;
`endif

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;

   state_t                 state;
   logic [SYNC_STAGES-1:0] sync;
   logic                   rxs;
   logic                   samp;
   logic [CW-1:0]          tick;
   logic [2:0]             bit_cnt;
   logic [7:0]             shreg;
   logic                   perr_p;
   logic                   par_exp;
   logic                   unused_sbn;

   // Second stop bit is never checked; the idle state absorbs it.
   assign unused_sbn = R_SBN;

   always_ff @(posedge BCLK) begin
      if (!RESET) sync <= '1;
      else        sync <= {sync[SYNC_STAGES-2:0], RX};
   end

   assign rxs = sync[SYNC_STAGES-1];

`ifdef ACIA_RX_MAJORITY_EN
   // hist holds rxs from the two previous ticks, so at a decision edge the
   // three votes are ticks N-2, N-1 and N.
   logic [1:0] hist;

   always_ff @(posedge BCLK) begin
      if (!RESET) hist <= '1;
      else        hist <= {hist[0], rxs};
   end

   assign samp = (hist[1] & hist[0]) | (hist[1] & rxs) | (hist[0] & rxs);
`else
   assign samp = rxs;
`endif

   always_comb begin
      par_exp = 1'b0;
      case (R_PMC)
         2'b00:   par_exp = ~^shreg;
         2'b01:   par_exp = ^shreg;
         2'b10:   par_exp = 1'b1;
         default: par_exp = 1'b0;
      endcase
   end

   always_ff @(posedge BCLK) begin
      if (!RESET) begin
         state   <= IDLE;
         tick    <= '0;
         bit_cnt <= '0;
         shreg   <= '0;
         perr_p  <= 1'b0;
         RXDATA  <= '0;
         RXFULL  <= 1'b0;
         PERR    <= 1'b0;
         FERR    <= 1'b0;
         OVRN    <= 1'b0;
      end else begin
         // Host acknowledge; a completion later in this block overrides it.
         if (RXREAD) begin
            RXFULL <= 1'b0;
            PERR   <= 1'b0;
            FERR   <= 1'b0;
            OVRN   <= 1'b0;
         end

         case (state)
            IDLE: begin
               tick    <= '0;
               bit_cnt <= '0;
               if (!rxs) state <= START;
            end

            START: begin
               tick <= tick + CW'(1);
               if (tick == START_PT) begin
                  if (samp) begin
                     state <= IDLE;
                  end else begin
                     tick   <= START_LOAD;
                     perr_p <= 1'b0;
                     state  <= DATA;
                  end
               end
            end

            // The tick counter wraps naturally, so each bit window is
            // exactly OVERSAMPLE ticks long.
            DATA: begin
               tick <= tick + CW'(1);
               if (tick == BIT_PT) begin
                  shreg   <= {samp, shreg[7:1]};
                  bit_cnt <= bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) state <= R_PME ? PARITY : STOP;
               end
            end

            PARITY: begin
               tick <= tick + CW'(1);
               if (tick == BIT_PT) begin
                  if (samp != par_exp) perr_p <= 1'b1;
                  state <= STOP;
               end
            end

            STOP: begin
               tick <= tick + CW'(1);
               if (tick == BIT_PT) begin
                  if (!RXFULL || RXREAD) begin
                     RXDATA <= shreg;
                     RXFULL <= 1'b1;
                     PERR   <= perr_p;
                     FERR   <= ~samp;
                     OVRN   <= 1'b0;
                  end else begin
                     OVRN   <= 1'b1;
                  end
                  state <= samp ? IDLE : BREAK;
               end
            end

            // A line held low must go high before another start is accepted.
            BREAK: begin
               tick <= '0;
               if (rxs) state <= IDLE;
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule
